or_rec8x8_seq: RTL and testbench



---
 rtl/or_rec8x8_seq.sv | 160 ++++++++++++++++
 tb/tb_or_rec8x8_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_rec8x8_seq.sv
// or_rec8x8_seq: sequential 8x8 recursive approximate multiplier.
// One shared or_4x4 (carry-free 4x4 product) is time-multiplexed over the
// four nibble sub-products. The sub-products are merged into a 16-bit
// accumulator.
// Ports:
//   clk, rst (synchronous, active-high)
//   in_valid/in_ready/a/b : operand handshake
//   out_valid/out_ready/y : result handshake
//   busy                  : high in MUL or DONE
// Parameter ZERO_SKIP: when 1, steps with a zero nibble are bypassed.
// Macro OR_MERGE_ACC_EN: if defined, the merge uses OR instead of addition.

module or_4x4 (
   input  logic [3:0] x,
   input  logic [3:0] w,
   output logic [7:0] p
);
   // Carry-free partial-product sum.
   // The top partial-product bit is x[3]&w[3] at weight 6, so p[7] is always 0.
   always_comb begin
      p = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (w[i]) p = p ^ ({4'h0, x} << i);
      end
   end
endmodule

module or_rec8x8_seq #(
   parameter int ZERO_SKIP = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] y,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t      state;
   logic [1:0]  step;
   logic [15:0] acc;
   logic [7:0]  aq, bq;
   logic [3:0]  mask_q;

   logic [3:0]  nx, nw;
   logic [3:0]  sh;
   logic [7:0]  pp;
   logic [15:0] shifted, acc_nxt;
   logic [3:0]  mask_in;
   logic [2:0]  first, nxt;

   // Bit i set when step i must execute.
   function automatic logic [3:0] run_mask(input logic [7:0] x,
                                           input logic [7:0] w);
      logic [3:0] r;
      if (ZERO_SKIP == 0) begin
         r = 4'hF;
      end else begin
         r[0] = (|x[3:0]) && (|w[3:0]);
         r[1] = (|x[7:4]) && (|w[3:0]);
         r[2] = (|x[3:0]) && (|w[7:4]);
         r[3] = (|x[7:4]) && (|w[7:4]);
      end
      return r;
   endfunction

   // Smallest executing step at or after 'from'; 3'd4 means none is left.
   function automatic logic [2:0] next_run(input logic [3:0] m,
                                           input logic [2:0] from);
      logic [2:0] r;
      r = 3'd4;
      for (int i = 3; i >= 0; i--) begin
         if (3'(i) >= from && m[i]) r = 3'(i);
      end
      return r;
   endfunction

   always_comb begin
      nx = aq[3:0];
      nw = bq[3:0];
      sh = 4'd0;
      unique case (step)
         2'd0: begin nx = aq[3:0]; nw = bq[3:0]; sh = 4'd0; end
         2'd1: begin nx = aq[7:4]; nw = bq[3:0]; sh = 4'd4; end
         2'd2: begin nx = aq[3:0]; nw = bq[7:4]; sh = 4'd4; end
         2'd3: begin nx = aq[7:4]; nw = bq[7:4]; sh = 4'd8; end
      endcase
   end

   or_4x4 u_mul (.x(nx), .w(nw), .p(pp));

   // A bypassed step has a zero nibble, so pp is 0 then.
   // The all-skipped single cycle therefore leaves acc at 0.
   always_comb begin
      shifted = {8'h00, pp} << sh;
`ifdef OR_MERGE_ACC_EN
      acc_nxt = acc | shifted;
`else
      acc_nxt = acc + shifted;
`endif
      mask_in = run_mask(a, b);
      first   = next_run(mask_in, 3'd0);
      nxt     = next_run(mask_q, {1'b0, step} + 3'd1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         step      <= 2'd0;
         acc       <= 16'h0000;
         aq        <= 8'h00;
         bq        <= 8'h00;
         mask_q    <= 4'h0;
         y         <= 16'h0000;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  aq       <= a;
                  bq       <= b;
                  mask_q   <= mask_in;
                  acc      <= 16'h0000;
                  step     <= first[2] ? 2'd0 : first[1:0];
                  state    <= MUL;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            MUL: begin
               acc <= acc_nxt;
               if (nxt[2]) begin
                  y         <= acc_nxt;
                  out_valid <= 1'b1;
                  step      <= 2'd0;
                  state     <= DONE;
               end else begin
                  step <= nxt[1:0];
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_or_rec8x8_seq.sv
// Testbench for or_rec8x8_seq: one instance without zero skip and one with.
// Results and latencies are compared against a nibble-level reference model.

module tb_or_rec8x8_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  a, b;
   logic        out_ready;
   logic        in_ready0, out_valid0, busy0;
   logic        in_ready1, out_valid1, busy1;
   logic [15:0] y0, y1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   or_rec8x8_seq #(.ZERO_SKIP(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
      .y(y0), .busy(busy0));

   or_rec8x8_seq #(.ZERO_SKIP(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
      .y(y1), .busy(busy1));

   // Carry-free 4x4 product: each column bit is the parity of its terms.
   function automatic int clmul4(input int x, input int w);
      int r = 0;
      for (int k = 0; k < 8; k++) begin
         int par = 0;
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
               if (i + j == k) par ^= ((x >> i) & 1) & ((w >> j) & 1);
         r |= par << k;
      end
      return r;
   endfunction

   function automatic int model_y(input int av, input int bv);
      int al = av % 16, ah = av / 16, bl = bv % 16, bh = bv / 16;
      int p0 = clmul4(al, bl);
      int p1 = clmul4(ah, bl) * 16;
      int p2 = clmul4(al, bh) * 16;
      int p3 = clmul4(ah, bh) * 256;
`ifdef OR_MERGE_ACC_EN
      return p0 | p1 | p2 | p3;
`else
      return (p0 + p1 + p2 + p3) % 65536;
`endif
   endfunction

   function automatic int model_lat(input int av, input int bv, input int zs);
      int n = 0;
      int an[2], bn[2];
      if (zs == 0) return 4;
      an[0] = av % 16; an[1] = av / 16;
      bn[0] = bv % 16; bn[1] = bv / 16;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            if (an[i] != 0 && bn[j] != 0) n++;
      return (n == 0) ? 1 : n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(in_ready0 && in_ready1) && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (!(in_ready0 && in_ready1)) begin
         bad++;
         $display("FAIL wait_idle: in_ready0=%0b in_ready1=%0b want 1", in_ready0, in_ready1);
      end
   endtask

   // Issue one operation with out_ready high, then check both latency and y.
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
      int l0 = -1, l1 = -1;
      logic [15:0] r0 = 16'h0, r1 = 16'h0;
      int e0 = model_lat(av, bv, 0);
      int e1 = model_lat(av, bv, 1);
      logic [15:0] ey = 16'(model_y(av, bv));
      wait_idle();
      out_ready = 1'b1;
      a = av; b = bv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (out_valid0 && l0 < 0) begin l0 = c; r0 = y0; end
         if (out_valid1 && l1 < 0) begin l1 = c; r1 = y1; end
      end
      total++;
      if (l0 !== e0) begin
         bad++;
         $display("FAIL lat0 a=%h b=%h: got %0d want %0d", av, bv, l0, e0);
      end
      total++;
      if (r0 !== ey) begin
         bad++;
         $display("FAIL y0 a=%h b=%h: got %h want %h", av, bv, r0, ey);
      end
      total++;
      if (l1 !== e1) begin
         bad++;
         $display("FAIL lat1 a=%h b=%h: got %0d want %0d", av, bv, l1, e1);
      end
      total++;
      if (r1 !== ey) begin
         bad++;
         $display("FAIL y1 a=%h b=%h: got %h want %h", av, bv, r1, ey);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      total++;
      if ({out_valid0, busy0, in_ready0, y0} !== {3'b001, 16'h0}) begin
         bad++;
         $display("FAIL reset0: ov=%b busy=%b ir=%b y=%h want 0 0 1 0000",
                  out_valid0, busy0, in_ready0, y0);
      end
      total++;
      if ({out_valid1, busy1, in_ready1, y1} !== {3'b001, 16'h0}) begin
         bad++;
         $display("FAIL reset1: ov=%b busy=%b ir=%b y=%h want 0 0 1 0000",
                  out_valid1, busy1, in_ready1, y1);
      end
   endtask

   task automatic test_directed();
      run_op(8'h23, 8'h11);
      run_op(8'hFF, 8'hFF);
      run_op(8'h0F, 8'h0F);
      run_op(8'h00, 8'h37);
      run_op(8'hF0, 8'h0F);
      run_op(8'h00, 8'h00);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [7:0] av = 8'($urandom);
         logic [7:0] bv = 8'($urandom);
         if ($urandom_range(0, 2) == 0) av[3:0] = 4'h0;
         if ($urandom_range(0, 2) == 0) bv[7:4] = 4'h0;
         run_op(av, bv);
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      logic [15:0] ey = 16'(model_y(8'hFF, 8'hFF));
      logic [15:0] ey2 = 16'(model_y(8'h5A, 8'hC3));
      wait_idle();
      out_ready = 1'b0;
      a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      tick();
      a = 8'h5A; b = 8'hC3;
      while (!out_valid0 && n < 10) begin tick(); n++; end
      total++;
      if (!out_valid0) begin
         bad++;
         $display("FAIL bp_result: out_valid0=%b want 1", out_valid0);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if ({out_valid0, in_ready0, y0} !== {2'b10, ey}) begin
            bad++;
            $display("FAIL bp_hold c=%0d: ov=%b ir=%b y=%h want 1 0 %h",
                     c, out_valid0, in_ready0, y0, ey);
         end
      end
      out_ready = 1'b1;
      tick();
      total++;
      if ({out_valid0, in_ready0, busy0} !== 3'b010) begin
         bad++;
         $display("FAIL bp_release: ov=%b ir=%b busy=%b want 0 1 0",
                  out_valid0, in_ready0, busy0);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if ({in_ready0, busy0} !== 2'b01) begin
         bad++;
         $display("FAIL bp_accept: ir=%b busy=%b want 0 1", in_ready0, busy0);
      end
      for (int c = 0; c < 3; c++) tick();
      total++;
      if (out_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL bp_early: out_valid0=%b want 0", out_valid0);
      end
      tick();
      total++;
      if ({out_valid0, y0} !== {1'b1, ey2}) begin
         bad++;
         $display("FAIL bp_second: ov=%b y=%h want 1 %h", out_valid0, y0, ey2);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      wait_idle();
      out_ready = 1'b1;
      a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({out_valid0, busy0, in_ready0, y0} !== {3'b001, 16'h0}) begin
         bad++;
         $display("FAIL mid_reset0: ov=%b busy=%b ir=%b y=%h want 0 0 1 0000",
                  out_valid0, busy0, in_ready0, y0);
      end
      total++;
      if ({out_valid1, busy1, in_ready1, y1} !== {3'b001, 16'h0}) begin
         bad++;
         $display("FAIL mid_reset1: ov=%b busy=%b ir=%b y=%h want 0 0 1 0000",
                  out_valid1, busy1, in_ready1, y1);
      end
      for (int c = 0; c < 6; c++) begin
         tick();
         total++;
         if (out_valid0 !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_emit c=%0d: out_valid0=%b want 0", c, out_valid0);
         end
      end
      run_op(8'h23, 8'h11);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1);
   end
endmodule
